// File: rtl/sc_spil_seqbuf.sv
// TX/RX word FIFOs plus a transfer sequencer feeding the SPI engine one word at a time.
// Single clock domain; every burst drains the TX FIFO into the engine and collects replies into RX.
module sc_spil_seqbuf #(
  parameter int DEPTH = 8,
  parameter int DW    = 32
) (
  input  logic          SYSCLK,
  input  logic          SYSRSTB,
  input  logic          CLR,
  input  logic          GO,
  input  logic          CSHOLDALL,
  input  logic          TXWE,
  input  logic [DW-1:0] TXWD,
  input  logic          RXRE,
  output logic [DW-1:0] RXRD,
  output logic [3:0]    TXDPT,
  output logic [3:0]    RXDPT,
  output logic          TXFULL,
  output logic          RXVALID,
  output logic          TXOVF,
  output logic          RXOVF,
  output logic          RXUNF,
  output logic          BUSY,
  output logic          DONE,
  output logic          ENG_TXSTART,
  output logic          ENG_CSEXTEND,
  output logic [DW-1:0] ENG_TXDATA,
  input  logic [DW-1:0] ENG_RXDATA,
  input  logic          ENG_COMPLETE
);
  localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]    DEPTH_C = 4'(DEPTH);
  localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_STORE} state_t;
  state_t state, state_nxt;

  logic          tx_pop, rx_push, clr_now;
  logic          tx_full, tx_wr, rx_full, rx_rd, rx_wr;
  logic [4:0]    tx_left;
  logic [PW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic [3:0]    tx_cnt, rx_cnt;
  logic [DW-1:0] tx_mem [DEPTH];
  logic [DW-1:0] rx_mem [DEPTH];
  logic [DW-1:0] rx_cap;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // ---------------- sequencer ----------------
  always_ff @(posedge SYSCLK or negedge SYSRSTB) begin
    if (!SYSRSTB) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (GO && !CLR && tx_cnt != 4'd0) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_START;
      S_START: state_nxt = S_WAIT;
      S_WAIT:  if (ENG_COMPLETE) state_nxt = S_STORE;
      S_STORE: state_nxt = (tx_cnt != 4'd0) ? S_LOAD : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    tx_pop      = (state == S_LOAD);
    ENG_TXSTART = (state == S_START);
    rx_push     = (state == S_STORE);
    DONE        = (state == S_STORE) && (tx_cnt == 4'd0);
    BUSY        = (state != S_IDLE);
    clr_now     = (state == S_IDLE) && CLR;
  end

  // ---------------- TX FIFO ----------------
  assign tx_full = (tx_cnt == DEPTH_C);
  // a pop in the same cycle frees the slot, so a write on full still lands
  assign tx_wr   = TXWE && !clr_now && (!tx_full || tx_pop);
  assign tx_left = 5'(tx_cnt) + 5'(tx_wr) - 5'd1;

  always_ff @(posedge SYSCLK or negedge SYSRSTB) begin
    if (!SYSRSTB) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
      TXOVF  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) tx_mem[i] <= '0;
    end else if (clr_now) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
      TXOVF  <= 1'b0;
    end else begin
      if (tx_wr) begin
        tx_mem[tx_wp] <= TXWD;
        tx_wp         <= ptr_inc(tx_wp);
      end
      if (tx_pop) tx_rp <= ptr_inc(tx_rp);
      tx_cnt <= tx_cnt + 4'(tx_wr) - 4'(tx_pop);
      if (TXWE && tx_full && !tx_pop) TXOVF <= 1'b1;
    end
  end

  // ---------------- engine side ----------------
  always_ff @(posedge SYSCLK or negedge SYSRSTB) begin
    if (!SYSRSTB) begin
      ENG_TXDATA   <= '0;
      ENG_CSEXTEND <= 1'b0;
      rx_cap       <= '0;
    end else begin
      if (tx_pop) begin
        ENG_TXDATA   <= tx_mem[tx_rp];
        ENG_CSEXTEND <= CSHOLDALL && (tx_left != 5'd0);
      end
      if (state == S_WAIT && ENG_COMPLETE) rx_cap <= ENG_RXDATA;
      if (DONE) ENG_CSEXTEND <= 1'b0;
    end
  end

  // ---------------- RX FIFO ----------------
  assign rx_full = (rx_cnt == DEPTH_C);
  assign rx_rd   = RXRE && !clr_now && (rx_cnt != 4'd0);
  assign rx_wr   = rx_push && (!rx_full || rx_rd);

  always_ff @(posedge SYSCLK or negedge SYSRSTB) begin
    if (!SYSRSTB) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
      RXOVF  <= 1'b0;
      RXUNF  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) rx_mem[i] <= '0;
    end else if (clr_now) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
      RXOVF  <= 1'b0;
      RXUNF  <= 1'b0;
    end else begin
      if (rx_wr) begin
        rx_mem[rx_wp] <= rx_cap;
        rx_wp         <= ptr_inc(rx_wp);
      end
      if (rx_rd) rx_rp <= ptr_inc(rx_rp);
      rx_cnt <= rx_cnt + 4'(rx_wr) - 4'(rx_rd);
      if (rx_push && rx_full && !rx_rd) RXOVF <= 1'b1;
      if (RXRE && rx_cnt == 4'd0)       RXUNF <= 1'b1;
    end
  end

  assign RXRD    = rx_mem[rx_rp];
  assign TXDPT   = tx_cnt;
  assign RXDPT   = rx_cnt;
  assign TXFULL  = tx_full;
  assign RXVALID = (rx_cnt != 4'd0);
endmodule

// File: tb/tb_sc_spil_seqbuf.sv
// Bench for sc_spil_seqbuf: echo-engine model plus queue-based expectations of FIFO order and counts.
module tb_sc_spil_seqbuf;
  localparam int DEPTH = 8;
  localparam int DW    = 32;

  logic clk = 1'b0, rst_n = 1'b0;
  logic clr = 1'b0, go = 1'b0, cshold = 1'b0, txwe = 1'b0, rxre = 1'b0;
  logic eng_complete = 1'b0;
  logic [DW-1:0] txwd = '0, eng_rxdata = '0;
  logic [DW-1:0] RXRD, ENG_TXDATA;
  logic [3:0] TXDPT, RXDPT;
  logic TXFULL, RXVALID, TXOVF, RXOVF, RXUNF, BUSY, DONE, ENG_TXSTART, ENG_CSEXTEND;

  sc_spil_seqbuf #(.DEPTH(DEPTH), .DW(DW)) dut (
    .SYSCLK(clk), .SYSRSTB(rst_n), .CLR(clr), .GO(go), .CSHOLDALL(cshold),
    .TXWE(txwe), .TXWD(txwd), .RXRE(rxre), .RXRD(RXRD), .TXDPT(TXDPT), .RXDPT(RXDPT),
    .TXFULL(TXFULL), .RXVALID(RXVALID), .TXOVF(TXOVF), .RXOVF(RXOVF), .RXUNF(RXUNF),
    .BUSY(BUSY), .DONE(DONE), .ENG_TXSTART(ENG_TXSTART), .ENG_CSEXTEND(ENG_CSEXTEND),
    .ENG_TXDATA(ENG_TXDATA), .ENG_RXDATA(eng_rxdata), .ENG_COMPLETE(eng_complete)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int starts = 0, dones = 0;
  bit eng_slow = 1'b0;
  logic [DW-1:0] st_data[$];
  bit            st_cs[$];
  logic [DW-1:0] exp_rx[$];

  // Engine model: answers every start with the inverted word after a few cycles.
  initial forever begin
    @(negedge clk);
    if (ENG_TXSTART) begin
      starts++;
      st_data.push_back(ENG_TXDATA);
      st_cs.push_back(ENG_CSEXTEND);
      repeat (eng_slow ? 20 : $urandom_range(1, 3)) @(negedge clk);
      eng_rxdata   = ~ENG_TXDATA;
      eng_complete = 1'b1;
      @(negedge clk);
      eng_complete = 1'b0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (DONE) dones++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_tx(input logic [DW-1:0] d);
    txwe = 1'b1; txwd = d;
    tick();
    txwe = 1'b0;
  endtask

  task automatic go_pulse();
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (BUSY && n < 400) begin tick(); n++; end
    n_tests++;
    if (BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_timeout: BUSY=%b required 0", nm, BUSY);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_tests++;
    if ({TXDPT, RXDPT} !== 8'h00 || RXRD !== '0 || ENG_TXDATA !== '0) begin
      n_fail++;
      $display("FAIL reset_data: TXDPT=%0d RXDPT=%0d RXRD=%h ENG_TXDATA=%h required all 0", TXDPT, RXDPT, RXRD, ENG_TXDATA);
    end
    n_tests++;
    if ({TXFULL, RXVALID, TXOVF, RXOVF, RXUNF, BUSY, DONE, ENG_TXSTART, ENG_CSEXTEND} !== 9'h0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 000000000",
               {TXFULL, RXVALID, TXOVF, RXOVF, RXUNF, BUSY, DONE, ENG_TXSTART, ENG_CSEXTEND});
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_burst3();
    logic [DW-1:0] w[3];
    int s0, d0;
    w[0] = 32'h0000_00A1; w[1] = 32'h0000_00B2; w[2] = 32'h0000_00C3;
    st_data.delete(); st_cs.delete();
    s0 = starts; d0 = dones;
    cshold = 1'b1;
    for (int i = 0; i < 3; i++) push_tx(w[i]);
    n_tests++;
    if (TXDPT !== 4'd3) begin n_fail++; $display("FAIL burst3_txdpt: got %0d required 3", TXDPT); end
    go = 1'b1;
    tick();
    go = 1'b0;
    n_tests++;
    if (BUSY !== 1'b1 || ENG_TXSTART !== 1'b0) begin
      n_fail++; $display("FAIL burst3_load: BUSY=%b TXSTART=%b required 1 0", BUSY, ENG_TXSTART);
    end
    tick();
    n_tests++;
    if (ENG_TXSTART !== 1'b1) begin n_fail++; $display("FAIL burst3_start_latency: TXSTART=%b required 1", ENG_TXSTART); end
    wait_idle("burst3");
    n_tests++;
    if (starts - s0 != 3 || dones - d0 != 1) begin
      n_fail++; $display("FAIL burst3_pulses: starts=%0d dones=%0d required 3 1", starts - s0, dones - d0);
    end
    n_tests++;
    if (st_cs.size() != 3 || st_cs[0] != 1'b1 || st_cs[1] != 1'b1 || st_cs[2] != 1'b0) begin
      n_fail++; $display("FAIL burst3_csextend: got %p required 1,1,0", st_cs);
    end
    n_tests++;
    if (st_data.size() != 3 || st_data[0] !== w[0] || st_data[1] !== w[1] || st_data[2] !== w[2]) begin
      n_fail++; $display("FAIL burst3_txdata: got %p required A1,B2,C3", st_data);
    end
    n_tests++;
    if (RXDPT !== 4'd3 || TXDPT !== 4'd0) begin
      n_fail++; $display("FAIL burst3_counts: RXDPT=%0d TXDPT=%0d required 3 0", RXDPT, TXDPT);
    end
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (RXRD !== ~w[i]) begin n_fail++; $display("FAIL burst3_rx%0d: got %h required %h", i, RXRD, ~w[i]); end
      rxre = 1'b1; tick(); rxre = 1'b0;
    end
    n_tests++;
    if (RXDPT !== 4'd0 || RXVALID !== 1'b0) begin
      n_fail++; $display("FAIL burst3_rx_empty: RXDPT=%0d RXVALID=%b required 0 0", RXDPT, RXVALID);
    end
  endtask

  task automatic test_join();
    logic [DW-1:0] x, y;
    x = $urandom; y = $urandom;
    st_data.delete(); st_cs.delete();
    cshold = 1'b1;
    push_tx(x);
    go_pulse();                       // now in LOAD: the write below lands alongside the pop
    txwe = 1'b1; txwd = y;
    tick();
    txwe = 1'b0;
    wait_idle("join");
    n_tests++;
    if (st_cs.size() != 2 || st_cs[0] != 1'b1 || st_cs[1] != 1'b0 || st_data[0] !== x || st_data[1] !== y) begin
      n_fail++; $display("FAIL join_burst: cs=%p data=%p required 1,0 and %h,%h", st_cs, st_data, x, y);
    end
    n_tests++;
    if (RXDPT !== 4'd2) begin n_fail++; $display("FAIL join_rxdpt: got %0d required 2", RXDPT); end
    n_tests++;
    if (RXRD !== ~x) begin n_fail++; $display("FAIL join_rx0: got %h required %h", RXRD, ~x); end
    rxre = 1'b1; tick();
    n_tests++;
    if (RXRD !== ~y) begin n_fail++; $display("FAIL join_rx1: got %h required %h", RXRD, ~y); end
    tick(); rxre = 1'b0;
  endtask

  task automatic test_txfull();
    for (int i = 0; i < DEPTH + 1; i++) push_tx($urandom);
    n_tests++;
    if (TXDPT !== 4'(DEPTH) || TXFULL !== 1'b1 || TXOVF !== 1'b1) begin
      n_fail++; $display("FAIL txfull: TXDPT=%0d TXFULL=%b TXOVF=%b required %0d 1 1", TXDPT, TXFULL, TXOVF, DEPTH);
    end
    clr = 1'b1; tick(); clr = 1'b0;
    n_tests++;
    if (TXDPT !== 4'd0 || TXOVF !== 1'b0 || TXFULL !== 1'b0) begin
      n_fail++; $display("FAIL txfull_clr: TXDPT=%0d TXOVF=%b TXFULL=%b required 0 0 0", TXDPT, TXOVF, TXFULL);
    end
  endtask

  task automatic test_rxovf();
    logic [DW-1:0] w[DEPTH];
    int d0;
    cshold = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin w[i] = $urandom; push_tx(w[i]); end
    go_pulse();
    wait_idle("rxfill");
    n_tests++;
    if (RXDPT !== 4'(DEPTH) || RXOVF !== 1'b0) begin
      n_fail++; $display("FAIL rxfill: RXDPT=%0d RXOVF=%b required %0d 0", RXDPT, RXOVF, DEPTH);
    end
    push_tx($urandom);
    d0 = dones;
    go_pulse();
    wait_idle("rxovf");
    n_tests++;
    if (RXOVF !== 1'b1 || RXDPT !== 4'(DEPTH) || dones - d0 != 1) begin
      n_fail++; $display("FAIL rxovf: RXOVF=%b RXDPT=%0d dones=%0d required 1 %0d 1", RXOVF, RXDPT, dones - d0, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) begin
      n_tests++;
      if (RXRD !== ~w[i]) begin n_fail++; $display("FAIL rxovf_rd%0d: got %h required %h", i, RXRD, ~w[i]); end
      rxre = 1'b1; tick(); rxre = 1'b0;
    end
    clr = 1'b1; tick(); clr = 1'b0;
    n_tests++;
    if (RXOVF !== 1'b0 || RXDPT !== 4'd0) begin
      n_fail++; $display("FAIL rxovf_clr: RXOVF=%b RXDPT=%0d required 0 0", RXOVF, RXDPT);
    end
  endtask

  task automatic test_go_empty();
    int s0, d0;
    bit busy_seen;
    s0 = starts; d0 = dones; busy_seen = 1'b0;
    go_pulse();
    for (int i = 0; i < 4; i++) begin busy_seen |= BUSY; tick(); end
    n_tests++;
    if (busy_seen || starts != s0 || dones != d0) begin
      n_fail++; $display("FAIL go_empty: busy=%b starts=%0d dones=%0d required 0 0 0", busy_seen, starts - s0, dones - d0);
    end
    rxre = 1'b1; tick(); rxre = 1'b0;
    n_tests++;
    if (RXUNF !== 1'b1 || RXDPT !== 4'd0) begin
      n_fail++; $display("FAIL rxunf: RXUNF=%b RXDPT=%0d required 1 0", RXUNF, RXDPT);
    end
    clr = 1'b1; tick(); clr = 1'b0;
    n_tests++;
    if (RXUNF !== 1'b0) begin n_fail++; $display("FAIL rxunf_clr: got %b required 0", RXUNF); end
  endtask

  task automatic test_clr_go();
    int s0;
    s0 = starts;
    push_tx($urandom); push_tx($urandom);
    clr = 1'b1; go = 1'b1;
    tick();
    clr = 1'b0; go = 1'b0;
    tick(); tick();
    n_tests++;
    if (BUSY !== 1'b0 || TXDPT !== 4'd0 || starts != s0) begin
      n_fail++; $display("FAIL clr_go: BUSY=%b TXDPT=%0d starts=%0d required 0 0 0", BUSY, TXDPT, starts - s0);
    end
  endtask

  task automatic test_reset_wait();
    int n, s0;
    cshold = 1'b1; eng_slow = 1'b1;
    push_tx($urandom); push_tx($urandom);
    go_pulse();
    n = 0;
    while (!ENG_TXSTART && n < 10) begin tick(); n++; end
    tick(); tick();
    n_tests++;
    if (BUSY !== 1'b1 || ENG_CSEXTEND !== 1'b1) begin
      n_fail++; $display("FAIL rstwait_pre: BUSY=%b CSEXTEND=%b required 1 1", BUSY, ENG_CSEXTEND);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({TXFULL, RXVALID, TXOVF, RXOVF, RXUNF, BUSY, DONE, ENG_TXSTART, ENG_CSEXTEND} !== 9'h0 ||
        TXDPT !== 4'd0 || ENG_TXDATA !== '0) begin
      n_fail++; $display("FAIL rstwait_async: flags=%b TXDPT=%0d TXDATA=%h required 0",
                         {TXFULL, RXVALID, TXOVF, RXOVF, RXUNF, BUSY, DONE, ENG_TXSTART, ENG_CSEXTEND}, TXDPT, ENG_TXDATA);
    end
    tick();
    rst_n = 1'b1; eng_slow = 1'b0;
    repeat (25) tick();
    n_tests++;
    if (BUSY !== 1'b0 || RXDPT !== 4'd0) begin
      n_fail++; $display("FAIL rstwait_stray_complete: BUSY=%b RXDPT=%0d required 0 0", BUSY, RXDPT);
    end
    s0 = starts;
    go_pulse();
    tick(); tick();
    n_tests++;
    if (BUSY !== 1'b0 || starts != s0) begin
      n_fail++; $display("FAIL rstwait_go_empty: BUSY=%b starts=%0d required 0 0", BUSY, starts - s0);
    end
  endtask

  task automatic test_stream();
    int rx_model, total, k, s0, d0, nrd, n, cs_bad;
    logic [DW-1:0] d;
    rx_model = 0; total = 0;
    exp_rx.delete();
    for (int b = 0; total < 24 && b < 50; b++) begin
      while (rx_model >= DEPTH) begin
        n_tests++;
        if (RXRD !== exp_rx[0]) begin n_fail++; $display("FAIL stream_drain: got %h required %h", RXRD, exp_rx[0]); end
        void'(exp_rx.pop_front());
        rxre = 1'b1; tick(); rxre = 1'b0;
        rx_model--;
      end
      k = $urandom_range(1, DEPTH - rx_model);
      cshold = 1'($urandom % 2);
      for (int j = 0; j < k; j++) begin
        d = $urandom;
        txwe = 1'b1; txwd = d;
        exp_rx.push_back(~d);
        rxre = (rx_model > 0) && ($urandom % 2 == 0);
        if (rxre) begin
          n_tests++;
          if (RXRD !== exp_rx[0]) begin n_fail++; $display("FAIL stream_idle_rd: got %h required %h", RXRD, exp_rx[0]); end
          void'(exp_rx.pop_front());
          rx_model--;
        end
        tick();
        n_tests++;
        if (TXDPT !== 4'(j + 1) || RXDPT !== 4'(rx_model)) begin
          n_fail++; $display("FAIL stream_cnt: TXDPT=%0d RXDPT=%0d required %0d %0d", TXDPT, RXDPT, j + 1, rx_model);
        end
      end
      txwe = 1'b0; rxre = 1'b0;
      st_cs.delete(); st_data.delete();
      s0 = starts; d0 = dones; nrd = 0; n = 0;
      go_pulse();
      while (BUSY && n < 400) begin
        rxre = RXVALID && ($urandom % 2 == 0);
        if (rxre) begin
          n_tests++;
          if (RXRD !== exp_rx[0]) begin n_fail++; $display("FAIL stream_busy_rd: got %h required %h", RXRD, exp_rx[0]); end
          void'(exp_rx.pop_front());
          nrd++;
        end
        tick(); n++;
      end
      rxre = 1'b0;
      rx_model = rx_model + k - nrd;
      n_tests++;
      if (BUSY !== 1'b0 || RXDPT !== 4'(rx_model) || TXDPT !== 4'd0) begin
        n_fail++; $display("FAIL stream_after: BUSY=%b RXDPT=%0d TXDPT=%0d required 0 %0d 0", BUSY, RXDPT, TXDPT, rx_model);
      end
      cs_bad = 0;
      for (int i = 0; i < k && i < st_cs.size(); i++)
        if (st_cs[i] != (cshold && i < k - 1)) cs_bad++;
      n_tests++;
      if (starts - s0 != k || dones - d0 != 1 || cs_bad != 0) begin
        n_fail++; $display("FAIL stream_burst: starts=%0d dones=%0d cs_bad=%0d required %0d 1 0", starts - s0, dones - d0, cs_bad, k);
      end
      total += k;
    end
    while (rx_model > 0) begin
      n_tests++;
      if (RXRD !== exp_rx[0]) begin n_fail++; $display("FAIL stream_final: got %h required %h", RXRD, exp_rx[0]); end
      void'(exp_rx.pop_front());
      rxre = 1'b1; tick(); rxre = 1'b0;
      rx_model--;
    end
    n_tests++;
    if (RXDPT !== 4'd0 || total < 20) begin
      n_fail++; $display("FAIL stream_end: RXDPT=%0d words=%0d required 0 >=20", RXDPT, total);
    end
  endtask

  initial begin
    test_reset();
    test_burst3();
    test_join();
    test_txfull();
    test_rxovf();
    test_go_empty();
    test_clr_go();
    test_reset_wait();
    test_stream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
